wb_burst_reader: RTL and testbench
==================================

Name: wb_burst_reader

Overview:
- Wishbone classic master that sits directly upstream of the team's Wishbone BlockRAM slave.
- On a start command, reads a contiguous run of 32-bit words from the slave.
- Buffers the words in an internal first-word-fall-through (FWFT) FIFO.
- Presents the words to a downstream consumer through a valid/ready stream, e.g. the pixel/display path reading a frame buffer.

Parameters:
- FIFO_DEPTH, 16, number of 32-bit entries in the internal FIFO; power of two, minimum 2.
- LEN_WIDTH, 16, width of the word-count input; maximum run is 2**LEN_WIDTH-1 words.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle command pulse; ignored while busy=1.
- base_adr  in  32  byte address of the first word; bits [1:0] are ignored (treated as 0).
- len  in  LEN_WIDTH  number of words to read; sampled together with start.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse when the last word has been accepted into the FIFO.
- wb_adr  out  32  Wishbone byte address.
- wb_dat_ms  out  32  Wishbone write data; always 0.
- wb_dat_sm  in  32  Wishbone read data.
- wb_we  out  1  always 0.
- wb_sel  out  4  always 4'b1111.
- wb_stb  out  1  strobe.
- wb_cyc  out  1  cycle; equal to wb_stb.
- wb_ack  in  1  slave acknowledge.
- out_data  out  32  FIFO head word.
- out_valid  out  1  FIFO not empty.
- out_ready  in  1  consumer accepts the head word when out_valid && out_ready.

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE.
  - busy=0, done=0, wb_stb=wb_cyc=0, wb_adr=0.
  - FIFO flushed: count=0, out_valid=0, out_data=0.
  - Reset mid-run abandons the run: no done pulse, FIFO contents lost, next cycle on the bus is idle.
- FSM states IDLE, RUN, FINISH:
  - IDLE:
    - start && len!=0 → RUN; latch adr=base_adr & ~3 and remaining=len.
    - start && len==0 → FINISH (no bus cycle issued).
  - RUN:
    - On each wb_ack: push wb_dat_sm into FIFO, adr+=4 (mod 2**32 wrap), remaining-=1.
    - Ack with remaining==1 → FINISH.
  - FINISH: done=1 for exactly this one cycle, busy=0, then → IDLE. A start in FINISH is ignored.
- busy=1 in RUN only. start while busy is ignored.
- Strobe rule (combinational from registered state): wb_stb = (state==RUN) && (count < FIFO_DEPTH).
  - At most one request outstanding.
  - count cannot rise between stb assertion and ack, so stb is held until ack as classic Wishbone requires.
  - A push therefore never occurs while the FIFO is full.
- Slave timing:
  - A read ack arrives ≥1 cycle after stb with data valid in the ack cycle.
  - Against the BRAM, continuous strobing yields one word every 2 cycles.
  - The master tolerates any wait-state count and must not count an ack seen while wb_stb=0 (ignored).
- wb_adr = latched adr while in RUN; it holds its last value otherwise.
- FIFO:
  - Pointers and count are registered; count width is log2(FIFO_DEPTH)+1.
  - Push on wb_ack && wb_stb. Pop on out_valid && out_ready.
  - Simultaneous push and pop leaves count unchanged.
  - Pop on empty is impossible (out_valid=0). Push on full is impossible per the strobe rule.
  - Pointers wrap modulo FIFO_DEPTH.
  - out_data is the head word; it is stable while out_valid && !out_ready.
- Ordering: words leave in ascending address order, none dropped or duplicated.
- done means "all words fetched", not "FIFO drained". A new run may start while the FIFO still holds data; its words queue behind.

Test Plan:
- Slave is wb_bram with mem_adr_width=11, memory preloaded so word k = 32'hA500_0000+k. Start with base_adr=0x10, len=4, out_ready=1 → wb_adr sequence 0x10,0x14,0x18,0x1C; out_data 0xA5000004..0xA5000007 in order; done pulses once, 1 cycle after the 4th ack; busy low afterwards.
- FIFO backpressure: FIFO_DEPTH=4, len=10, out_ready=0 → exactly 4 acks, then wb_stb stays 0 and count=4. Raise out_ready → remaining 6 words fetched; total stream 10 words, in order.
- len=0 → done pulses the cycle after start; wb_stb never asserted.
- start pulsed again while busy → ignored; run length and addresses unchanged.
- Random wait states (0-3 cycles) on a behavioural slave with base_adr=0xFFFF_FFF8, len=4 → addresses 0xFFFFFFF8, 0xFFFFFFFC, 0x0, 0x4 (wrap); data correct.
- Assert rst during word 3 of 8 → all outputs reach reset values asynchronously; after release, a new run with len=2 completes cleanly.

Source files
------------

// File: rtl/wb_burst_reader.sv
// Wishbone classic burst reader: fetches a run of words from a slave
// and streams them to a consumer through an internal FWFT FIFO.
module wb_burst_reader #(
  parameter int FIFO_DEPTH = 16,
  parameter int LEN_WIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [31:0]          base_adr,
  input  logic [LEN_WIDTH-1:0] len,
  output logic                 busy,
  output logic                 done,
  output logic [31:0]          wb_adr,
  output logic [31:0]          wb_dat_ms,
  input  logic [31:0]          wb_dat_sm,
  output logic                 wb_we,
  output logic [3:0]           wb_sel,
  output logic                 wb_stb,
  output logic                 wb_cyc,
  input  logic                 wb_ack,
  output logic [31:0]          out_data,
  output logic                 out_valid,
  input  logic                 out_ready
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FINISH
  } state_t;

  state_t               state;
  logic [31:0]          adr;
  logic [LEN_WIDTH-1:0] remaining;

  logic [31:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          push;
  logic          pop;

  // Strobe only while room remains; count cannot grow while a
  // request is outstanding, so stb stays up until its ack.
  assign wb_stb    = (state == RUN) && (count < CW'(FIFO_DEPTH));
  assign wb_cyc    = wb_stb;
  assign wb_adr    = adr;
  assign wb_dat_ms = '0;
  assign wb_we     = 1'b0;
  assign wb_sel    = 4'b1111;

  assign push      = wb_stb && wb_ack;
  assign out_valid = (count != '0);
  assign pop       = out_valid && out_ready;
  assign out_data  = out_valid ? mem[rd_ptr] : '0;

  // Run control: accept commands, step address, flag completion.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      adr       <= '0;
      remaining <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            if (len != '0) begin
              state     <= RUN;
              busy      <= 1'b1;
              adr       <= base_adr & ~32'd3;
              remaining <= len;
            end else begin
              state <= FINISH;
              done  <= 1'b1;
            end
          end
        end
        RUN: begin
          if (push) begin
            if (remaining == LEN_WIDTH'(1)) begin
              state <= FINISH;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              adr       <= adr + 32'd4;
              remaining <= remaining - LEN_WIDTH'(1);
            end
          end
        end
        FINISH: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // FIFO storage; contents need no reset since out_data is gated.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wb_dat_sm;
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      unique case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_burst_reader.sv
// Directed bench for wb_burst_reader against a behavioural
// BRAM-like slave with programmable random wait states.
module tb_wb_burst_reader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] base_adr;
  logic [15:0] len;
  logic        busy;
  logic        done;
  logic [31:0] wb_adr;
  logic [31:0] wb_dat_ms;
  logic [31:0] wb_dat_sm;
  logic        wb_we;
  logic [3:0]  wb_sel;
  logic        wb_stb;
  logic        wb_cyc;
  logic        wb_ack;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready;

  logic        ack_r;
  logic        force_ack;
  int          max_wait;
  int          cur_wait;
  int          wcnt;

  int total = 0;
  int bad   = 0;

  logic [31:0] adr_q[$];
  logic [31:0] dat_q[$];
  int          done_cnt;
  int          stb_seen;
  int          cyc;
  int          last_ack_cyc;
  int          done_cyc;

  typedef struct {
    logic [31:0]       base;
    int                n;
    int                wt;
    logic [0:3][31:0]  exp_adr;
    logic [0:3][31:0]  exp_dat;
  } vec_t;

  vec_t vecs[4];

  wb_burst_reader #(
    .FIFO_DEPTH(4),
    .LEN_WIDTH (16)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .base_adr (base_adr),
    .len      (len),
    .busy     (busy),
    .done     (done),
    .wb_adr   (wb_adr),
    .wb_dat_ms(wb_dat_ms),
    .wb_dat_sm(wb_dat_sm),
    .wb_we    (wb_we),
    .wb_sel   (wb_sel),
    .wb_stb   (wb_stb),
    .wb_cyc   (wb_cyc),
    .wb_ack   (wb_ack),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] bram_word(input logic [31:0] a);
    return 32'hA500_0000 + {21'd0, a[12:2]};
  endfunction

  assign wb_ack = ack_r | force_ack;

  // Slave: ack one cycle after strobe plus 0..max_wait wait states.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      ack_r    <= 1'b0;
      wcnt     <= 0;
      cur_wait <= 0;
    end else if (ack_r) begin
      ack_r <= 1'b0;
    end else if (wb_stb) begin
      if (wcnt >= cur_wait) begin
        ack_r     <= 1'b1;
        wb_dat_sm <= bram_word(wb_adr);
        wcnt      <= 0;
        cur_wait  <= int'($urandom_range(0, max_wait));
      end else begin
        wcnt <= wcnt + 1;
      end
    end
  end

  // Monitor bus acks, stream pops and done pulses.
  always @(posedge clk) begin
    cyc = cyc + 1;
    if (!rst) begin
      if (wb_stb && wb_ack) begin
        adr_q.push_back(wb_adr);
        last_ack_cyc = cyc;
      end
      if (out_valid && out_ready) dat_q.push_back(out_data);
      if (done) begin
        done_cnt = done_cnt + 1;
        done_cyc = cyc;
      end
      if (wb_stb) stb_seen = 1;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  task automatic clear_mon();
    adr_q.delete();
    dat_q.delete();
    done_cnt     = 0;
    stb_seen     = 0;
    last_ack_cyc = 0;
    done_cyc     = 0;
  endtask

  task automatic do_start(input logic [31:0] b, input logic [15:0] l);
    @(negedge clk);
    base_adr = b;
    len      = l;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (done_cnt == 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (out_valid && n < budget) begin
      @(negedge clk);
      n++;
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    base_adr  = '0;
    len       = '0;
    out_ready = 1'b1;
    force_ack = 1'b0;
    max_wait  = 0;
    wb_dat_sm = '0;
    cyc       = 0;
    clear_mon();

    vecs[0] = '{32'h0000_0010, 4, 0,
      {32'h10, 32'h14, 32'h18, 32'h1C},
      {32'hA500_0004, 32'hA500_0005, 32'hA500_0006, 32'hA500_0007}};
    vecs[1] = '{32'hFFFF_FFF8, 4, 3,
      {32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0, 32'h4},
      {32'hA500_07FE, 32'hA500_07FF, 32'hA500_0000, 32'hA500_0001}};
    vecs[2] = '{32'h0000_0013, 3, 1,
      {32'h10, 32'h14, 32'h18, 32'h0},
      {32'hA500_0004, 32'hA500_0005, 32'hA500_0006, 32'h0}};
    vecs[3] = '{32'h0000_1FFC, 2, 2,
      {32'h1FFC, 32'h2000, 32'h0, 32'h0},
      {32'hA500_07FF, 32'hA500_0000, 32'h0, 32'h0}};

    #12;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_stb", wb_stb, 0);
    chk("rst_cyc", wb_cyc, 0);
    chk("rst_adr", wb_adr, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("const_we", wb_we, 0);
    chk("const_sel", wb_sel, 4'hF);
    chk("const_dat_ms", wb_dat_ms, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 4; i++) begin
      clear_mon();
      max_wait = vecs[i].wt;
      do_start(vecs[i].base, 16'(vecs[i].n));
      wait_done(200);
      drain(100);
      chk($sformatf("v%0d_acks", i), adr_q.size(), vecs[i].n);
      chk($sformatf("v%0d_words", i), dat_q.size(), vecs[i].n);
      for (int j = 0; j < vecs[i].n && j < adr_q.size(); j++)
        chk($sformatf("v%0d_adr%0d", i, j), adr_q[j], vecs[i].exp_adr[j]);
      for (int j = 0; j < vecs[i].n && j < dat_q.size(); j++)
        chk($sformatf("v%0d_dat%0d", i, j), dat_q[j], vecs[i].exp_dat[j]);
      chk($sformatf("v%0d_done_cnt", i), done_cnt, 1);
      chk($sformatf("v%0d_done_gap", i), done_cyc - last_ack_cyc, 1);
      chk($sformatf("v%0d_busy_end", i), busy, 0);
      chk($sformatf("v%0d_stb_end", i), wb_stb, 0);
    end

    // Zero-length command: done next cycle, no bus activity.
    clear_mon();
    @(negedge clk);
    len   = 16'd0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("len0_done", done, 1);
    chk("len0_busy", busy, 0);
    @(negedge clk);
    chk("len0_done_low", done, 0);
    chk("len0_stb_seen", stb_seen, 0);
    chk("len0_done_cnt", done_cnt, 1);

    // Spurious ack while idle must not push.
    @(negedge clk);
    force_ack = 1'b1;
    @(negedge clk);
    force_ack = 1'b0;
    @(negedge clk);
    chk("stray_ack_valid", out_valid, 0);
    chk("stray_ack_count", dut.count, 0);

    // Second start while busy is ignored.
    clear_mon();
    max_wait = 2;
    do_start(32'h40, 16'd3);
    repeat (2) @(negedge clk);
    chk("busy_mid", busy, 1);
    base_adr = 32'h100;
    len      = 16'd5;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(200);
    drain(100);
    repeat (4) @(negedge clk);
    chk("restart_acks", adr_q.size(), 3);
    if (adr_q.size() == 3) begin
      chk("restart_adr0", adr_q[0], 32'h40);
      chk("restart_adr2", adr_q[2], 32'h48);
    end
    chk("restart_done_cnt", done_cnt, 1);
    chk("restart_busy", busy, 0);

    // Backpressure: FIFO of 4 fills, strobe stops.
    clear_mon();
    max_wait  = 0;
    out_ready = 1'b0;
    do_start(32'h0, 16'd10);
    repeat (40) @(negedge clk);
    chk("bp_acks", adr_q.size(), 4);
    chk("bp_stb", wb_stb, 0);
    chk("bp_count", dut.count, 4);
    chk("bp_valid", out_valid, 1);
    chk("bp_head", out_data, 32'hA500_0000);
    chk("bp_busy", busy, 1);
    out_ready = 1'b1;
    wait_done(300);
    drain(100);
    chk("bp_total_acks", adr_q.size(), 10);
    chk("bp_total_words", dat_q.size(), 10);
    for (int j = 0; j < 10 && j < dat_q.size(); j++)
      chk($sformatf("bp_dat%0d", j), dat_q[j], 32'hA500_0000 + j);
    chk("bp_done_cnt", done_cnt, 1);

    // Reset during word 3 of 8.
    clear_mon();
    max_wait = 0;
    do_start(32'h0, 16'd8);
    begin
      int n = 0;
      while (adr_q.size() < 2 && n < 100) begin
        @(negedge clk);
        n++;
      end
    end
    chk("mid_acks", adr_q.size(), 2);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_stb", wb_stb, 0);
    chk("mid_rst_cyc", wb_cyc, 0);
    chk("mid_rst_adr", wb_adr, 0);
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_data", out_data, 0);
    chk("mid_rst_done", done, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_stb", wb_stb, 0);
    chk("post_rst_done_cnt", done_cnt, 0);
    clear_mon();
    do_start(32'h80, 16'd2);
    wait_done(200);
    drain(100);
    chk("post_acks", adr_q.size(), 2);
    chk("post_words", dat_q.size(), 2);
    if (dat_q.size() == 2) begin
      chk("post_dat0", dat_q[0], 32'hA500_0020);
      chk("post_dat1", dat_q[1], 32'hA500_0021);
    end
    chk("post_done_cnt", done_cnt, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
